tick_meter: RTL

Measures the interval, in `clk` cycles, between successive rising edges of a periodic pulse, such as the 1-cycle tick from the frequency divider. It reports each interval with a 1-cycle valid strobe and tracks the minimum and maximum intervals seen. It flags a timeout when no edge arrives within `MAX_COUNT` cycles. It sits on the consumer side of the tick path and is used to check divider outputs on hardware and in simulation.

---
 rtl/tick_meter_pkg.sv | 14 +
 rtl/tick_meter_rise_detect.sv | 22 ++
 rtl/tick_meter.sv | 90 +++++++++
 3 files changed

// File: rtl/tick_meter_pkg.sv
// Shared types and constants for the tick interval meter.
// Imported by the top level and anything that decodes its state.
package tick_meter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      TIMEOUT
   } tm_state_t;

   // Wide all-ones pattern; users slice it down to their period width.
   localparam logic [63:0] TM_MIN_INIT = '1;

endpackage

// File: rtl/tick_meter_rise_detect.sv
// Registered rising-edge detector: rise is high in the cycle d goes 0->1.
// The history register is cleared only by rst, so a held-high input never re-triggers.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic d_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         d_q <= 1'b0;
      end else begin
         d_q <= d;
      end
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/tick_meter.sv
// Measures clk cycles between rising edges of tick_in, tracks min/max and flags
// a timeout when no edge arrives within MAX_COUNT cycles. All outputs registered.
module tick_meter
   import tick_meter_pkg::*;
#(
   parameter int unsigned MAX_COUNT = 200_000_000,
   localparam int unsigned NB = $clog2(MAX_COUNT + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick_in,
   input  logic          clear,
   output logic [NB-1:0] period,
   output logic          period_valid,
   output logic [NB-1:0] period_min,
   output logic [NB-1:0] period_max,
   output logic          timeout,
   output logic          armed
);

   localparam logic [NB-1:0] MaxCnt  = NB'(MAX_COUNT);
   localparam logic [NB-1:0] MinInit = TM_MIN_INIT[NB-1:0];

   tm_state_t     state;
   logic [NB-1:0] cnt;
   logic          tick_rise;

   rise_detect u_rise_detect (
      .clk  (clk),
      .rst  (rst),
      .d    (tick_in),
      .rise (tick_rise)
   );

   always_ff @(posedge clk) begin
      period_valid <= 1'b0;
      if (rst || clear) begin
         state      <= IDLE;
         cnt        <= '0;
         period     <= '0;
         period_min <= MinInit;
         period_max <= '0;
         timeout    <= 1'b0;
         armed      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               // The first edge only opens an interval; nothing to report yet.
               if (tick_rise) begin
                  state <= MEASURE;
                  cnt   <= NB'(1);
                  armed <= 1'b1;
               end
            end
            MEASURE: begin
               // An edge on the threshold cycle still counts as a valid period.
               if (tick_rise) begin
                  period       <= cnt;
                  period_valid <= 1'b1;
                  if (cnt < period_min) period_min <= cnt;
                  if (cnt > period_max) period_max <= cnt;
                  cnt <= NB'(1);
               end else if (cnt == MaxCnt) begin
                  state   <= TIMEOUT;
                  timeout <= 1'b1;
                  armed   <= 1'b0;
               end else begin
                  cnt <= cnt + NB'(1);
               end
            end
            TIMEOUT: begin
               // The stale interval is discarded; measurement restarts here.
               if (tick_rise) begin
                  state   <= MEASURE;
                  timeout <= 1'b0;
                  cnt     <= NB'(1);
                  armed   <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               cnt     <= '0;
               timeout <= 1'b0;
               armed   <= 1'b0;
            end
         endcase
      end
   end

endmodule
